// File: rtl/dlsc_axi_router_channel_source_pkg.sv
// Shared types for the router channel source stage.
package dlsc_axi_router_channel_source_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_REQ,
    ST_XFER,
    ST_DROP
  } state_t;

endpackage

// File: rtl/dlsc_axi_router_channel_source.sv
// Router channel ingress: posts a sink command, wins a lane, then streams the burst onto it.
// Bursts to a nonexistent sink are drained and flagged via err_sink.
module dlsc_axi_router_channel_source
  import dlsc_axi_router_channel_source_pkg::*;
#(
  parameter int DATA   = 32,
  parameter int SINKS  = 1,
  parameter int SINKSB = 1,
  parameter int LANES  = 1,
  parameter int LANESB = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              src_ready,
  input  logic              src_valid,
  input  logic              src_last,
  input  logic [DATA-1:0]   src_data,
  input  logic [SINKSB-1:0] src_sink,
  input  logic [SINKS-1:0]  cmd_full,
  output logic [SINKS-1:0]  cmd_push,
  output logic              arb_req,
  output logic [SINKSB-1:0] arb_sink,
  input  logic              arb_grant,
  input  logic [LANESB-1:0] arb_grant_lane,
  input  logic [LANES-1:0]  lane_in_ready,
  output logic [LANES-1:0]  lane_in_valid,
  output logic              lane_in_last,
  output logic [DATA-1:0]   lane_in_data,
  output logic              err_sink
);

  state_t            state, state_nxt;
  logic [SINKSB-1:0] sink, sink_nxt;
  logic [LANESB-1:0] lane, lane_nxt;
  logic [SINKS-1:0]  push_nxt;
  logic              err_nxt;

  logic [SINKS-1:0]  src_sink_hot;
  logic [LANES-1:0]  lane_hot;
  logic              src_sink_bad;
  logic              src_sink_full;
  logic              lane_ready;

  // Decoders compare against the full index so out-of-range sinks select nothing.
  always_comb begin
    src_sink_hot  = '0;
    lane_hot      = '0;
    src_sink_full = 1'b0;
    lane_ready    = 1'b0;
    for (int unsigned i = 0; i < SINKS; i++) begin
      if (32'(src_sink) == i) begin
        src_sink_hot[i] = 1'b1;
        src_sink_full   = cmd_full[i];
      end
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      if (32'(lane) == i) begin
        lane_hot[i] = 1'b1;
        lane_ready  = lane_in_ready[i];
      end
    end
  end

  assign src_sink_bad = 32'(src_sink) >= 32'(SINKS);

  always_comb begin
    state_nxt     = state;
    sink_nxt      = sink;
    lane_nxt      = lane;
    push_nxt      = '0;
    err_nxt       = 1'b0;
    src_ready     = 1'b0;
    arb_req       = 1'b0;
    arb_sink      = sink;
    lane_in_valid = '0;
    lane_in_last  = src_last;
    lane_in_data  = src_data;
    case (state)
      ST_IDLE: begin
        if (src_valid) begin
          if (src_sink_bad) begin
            state_nxt = ST_DROP;
          end else if (!src_sink_full) begin
            sink_nxt  = src_sink;
            push_nxt  = src_sink_hot;
            state_nxt = ST_CMD;
          end
        end
      end
      ST_CMD: state_nxt = ST_REQ;
      ST_REQ: begin
        arb_req = 1'b1;
        if (arb_grant) begin
          lane_nxt  = arb_grant_lane;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        src_ready = lane_ready;
        if (src_valid) lane_in_valid = lane_hot;
        if (src_valid && lane_ready && src_last) state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        src_ready = 1'b1;
        if (src_valid && src_last) begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sink     <= '0;
      lane     <= '0;
      cmd_push <= '0;
      err_sink <= 1'b0;
    end else begin
      state    <= state_nxt;
      sink     <= sink_nxt;
      lane     <= lane_nxt;
      cmd_push <= push_nxt;
      err_sink <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    assert (rst || !arb_grant || state == ST_REQ) else $error("dlsc_error: spurious grant");
  end

endmodule
